exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception sequencer in front of the CP0 register file.
- Takes per-source exception requests from the execute stage and filters them against the live CP0 status word.
- Picks one request by priority and drives CP0's exception/eret/cause/pc inputs as single-cycle pulses, with a matching pipeline flush.
- Tracks whether a handler is in progress and holds one further request pending until eret.

Parameters:
- WDOG_CYCLES, 1024: handler watchdog limit in clk cycles (used only with EXC_WDOG_EN).
- WDOG_W, 11: watchdog counter width; must satisfy 2^WDOG_W > WDOG_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-low.
- stall  in  1  pipeline stall; while 1, no new exception entry or eret is issued.
- req_syscall  in  1  syscall request, level, from execute stage.
- req_break  in  1  break request.
- req_ovf  in  1  arithmetic overflow request.
- req_teq  in  1  teq trap request.
- req_pc  in  32  pc of the requesting instruction.
- eret_req  in  1  eret instruction decoded.
- status  in  32  CP0 status register (reg 12).
- exception  out  1  to CP0 exception input; one-cycle pulse.
- eret  out  1  to CP0 eret input; one-cycle pulse.
- cause  out  2  to CP0 cause input: 00 syscall (8), 01 break (9), 10 overflow (12), 11 teq (13).
- exc_pc  out  32  to CP0 pc input; valid while exception=1.
- flush  out  1  pipeline flush; high in the same cycle as exception.
- busy  out  1  high from the entry cycle through the eret cycle.
- pending  out  1  one request is latched and waiting.
- wdog_fault  out  1  sticky watchdog expiry flag; constant 0 when the macro is off.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; exception, eret, flush, busy, pending, wdog_fault = 0; cause=0; exc_pc=0; pending slot and counter cleared.
- Enable rule: a source is accepted only when status[0]=1 and its own bit is set: syscall status[1], break status[2], ovf status[3], teq status[4]. CP0 shifts status left by 5 on entry, so nested sources are masked automatically.
- Priority, highest first: teq > ovf > break > syscall.
- States:
  - IDLE:
    - If stall=0 and the pending slot is valid with its source enabled: go to ENTER using the slot's cause/pc, and clear the slot.
    - Otherwise, if stall=0 and any live request is enabled: go to ENTER with the highest-priority enabled live request and req_pc.
    - The pending slot beats live requests.
    - Disabled requests in IDLE are dropped.
    - A pending slot whose source is disabled stays held.
  - ENTER: exception=1, flush=1, busy=1 for exactly one cycle; cause and exc_pc are registered. Always go to HANDLER next.
  - HANDLER: busy=1. eret_req=1 with stall=0 goes to RETURN.
  - RETURN: eret=1, busy=1 for one cycle, then IDLE.
- Latency: a live request sampled in IDLE at cycle t gives exception=1 in cycle t+1; eret_req sampled in HANDLER at t gives eret=1 in t+1.
- Requests in ENTER, HANDLER or RETURN:
  - The highest-priority request is latched (cause+pc) into a one-deep pending slot if the slot is empty. No enable check is applied at latch time.
  - If the slot is full, the new request is dropped.
  - The slot is never overwritten.
- eret_req in IDLE or ENTER is ignored; no eret pulse is issued.
- Simultaneous request and eret_req in HANDLER: the request is latched as pending and the eret is taken.
- A stall in HANDLER delays the eret; a stall in ENTER/RETURN does not extend the pulse.
- A reset in any state aborts immediately to IDLE with outputs at their reset values; the pending request is lost.

Optional Feature:
- Macro EXC_WDOG_EN.
- Defined:
  - A counter clears on entry to HANDLER and increments each HANDLER cycle.
  - When it reaches WDOG_CYCLES without eret_req: force RETURN (eret pulse to unwind status) and set wdog_fault=1 until reset.
- Undefined: no counter; wdog_fault tied 0; HANDLER waits indefinitely.

Test Plan:
- Basic entry: status=0x1F, req_syscall=1, req_pc=0x00400010 in IDLE → next cycle exception=1, flush=1, cause=00, exc_pc=0x00400010; one cycle later busy=1, exception=0.
- Priority: status=0x1F, req_syscall=req_teq=req_ovf=1 together → cause=11 (teq); ovf latched into the pending slot (pending=1); syscall dropped.
- Masking: status=0x1B (break disabled), req_break=1 in IDLE → no exception; status=0x1E (IE=0), req_teq=1 → no exception.
- Pending replay: in HANDLER, req_ovf=1 at pc 0x00400020, then eret_req → eret pulse, back in IDLE; with status=0x1F, exception next cycle with cause=10, exc_pc=0x00400020, pending=0.
- Stall and spurious eret: eret_req in IDLE → eret stays 0. In HANDLER, eret_req held with stall=1 for 3 cycles → eret=0; the cycle after stall drops → eret=1 for one cycle.
- Reset and watchdog: rst=0 during HANDLER → next cycle busy=0, pending=0. With EXC_WDOG_EN and WDOG_CYCLES=8, no eret → eret pulse 8 HANDLER cycles after entry, wdog_fault=1 and held.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception sequencer in front of CP0: filters, prioritises and issues exception/eret pulses.
// Optional handler watchdog enabled by defining EXC_WDOG_EN.
module exc_ctrl
`ifdef EXC_WDOG_EN
#(
   parameter int unsigned WDOG_CYCLES = 1024,
   parameter int unsigned WDOG_W      = 11
)
`endif
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        req_syscall,
   input  logic        req_break,
   input  logic        req_ovf,
   input  logic        req_teq,
   input  logic [31:0] req_pc,
   input  logic        eret_req,
   input  logic [31:0] status,
   output logic        exception,
   output logic        eret,
   output logic [1:0]  cause,
   output logic [31:0] exc_pc,
   output logic        flush,
   output logic        busy,
   output logic        pending,
   output logic        wdog_fault
);

   typedef enum logic [1:0] {S_IDLE, S_ENTER, S_HANDLER, S_RETURN} state_e;

   state_e      state_q, state_d;
   logic        exc_q, exc_d;
   logic        eret_q, eret_d;
   logic        flush_q, flush_d;
   logic        busy_q, busy_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] exc_pc_q, exc_pc_d;
   logic        pend_vld_q, pend_vld_d;
   logic [1:0]  pend_cause_q, pend_cause_d;
   logic [31:0] pend_pc_q, pend_pc_d;

   logic [3:0]  req_raw_c;
   logic [3:0]  en_mask_c;
   logic [3:0]  req_en_c;
   logic [1:0]  top_en_c;
   logic [3:0]  rest_en_c;
   logic        pend_en_c;
   logic        unused_status;

   // Highest index wins: teq(3) > ovf(2) > break(1) > syscall(0); index equals cause code.
   function automatic logic [1:0] pick_hi(input logic [3:0] v);
      if (v[3])      return 2'd3;
      else if (v[2]) return 2'd2;
      else if (v[1]) return 2'd1;
      else           return 2'd0;
   endfunction

   assign req_raw_c     = {req_teq, req_ovf, req_break, req_syscall};
   assign en_mask_c     = status[0] ? status[4:1] : 4'b0000;
   assign req_en_c      = req_raw_c & en_mask_c;
   assign top_en_c      = pick_hi(req_en_c);
   assign rest_en_c     = req_en_c & ~(4'b0001 << top_en_c);
   assign pend_en_c     = en_mask_c[pend_cause_q];
   assign unused_status = ^status[31:5];

`ifdef EXC_WDOG_EN
   logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
   logic              wdog_fault_q, wdog_fault_d;
`endif

   // Next-state, pending slot and registered-output computation.
   always_comb begin
      state_d      = state_q;
      cause_d      = cause_q;
      exc_pc_d     = exc_pc_q;
      pend_vld_d   = pend_vld_q;
      pend_cause_d = pend_cause_q;
      pend_pc_d    = pend_pc_q;
`ifdef EXC_WDOG_EN
      wdog_cnt_d   = wdog_cnt_q;
      wdog_fault_d = wdog_fault_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (!stall && pend_vld_q && pend_en_c) begin
               state_d    = S_ENTER;
               cause_d    = pend_cause_q;
               exc_pc_d   = pend_pc_q;
               pend_vld_d = 1'b0;
            end else if (!stall && (|req_en_c)) begin
               state_d  = S_ENTER;
               cause_d  = top_en_c;
               exc_pc_d = req_pc;
               // The runner-up of a simultaneous group is kept rather than lost.
               if (!pend_vld_q && (|rest_en_c)) begin
                  pend_vld_d   = 1'b1;
                  pend_cause_d = pick_hi(rest_en_c);
                  pend_pc_d    = req_pc;
               end
            end
         end
         S_ENTER: begin
            state_d = S_HANDLER;
`ifdef EXC_WDOG_EN
            wdog_cnt_d = '0;
`endif
         end
         S_HANDLER: begin
            if (eret_req && !stall) begin
               state_d = S_RETURN;
`ifdef EXC_WDOG_EN
            end else if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
               state_d      = S_RETURN;
               wdog_fault_d = 1'b1;
            end else begin
               wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outside IDLE, one request may be parked without an enable check.
      if (state_q != S_IDLE && !pend_vld_q && (|req_raw_c)) begin
         pend_vld_d   = 1'b1;
         pend_cause_d = pick_hi(req_raw_c);
         pend_pc_d    = req_pc;
      end

      exc_d   = (state_d == S_ENTER);
      flush_d = (state_d == S_ENTER);
      eret_d  = (state_d == S_RETURN);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         exc_q        <= 1'b0;
         eret_q       <= 1'b0;
         flush_q      <= 1'b0;
         busy_q       <= 1'b0;
         cause_q      <= 2'd0;
         exc_pc_q     <= 32'd0;
         pend_vld_q   <= 1'b0;
         pend_cause_q <= 2'd0;
         pend_pc_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         exc_q        <= exc_d;
         eret_q       <= eret_d;
         flush_q      <= flush_d;
         busy_q       <= busy_d;
         cause_q      <= cause_d;
         exc_pc_q     <= exc_pc_d;
         pend_vld_q   <= pend_vld_d;
         pend_cause_q <= pend_cause_d;
         pend_pc_q    <= pend_pc_d;
      end
   end

`ifdef EXC_WDOG_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         wdog_cnt_q   <= '0;
         wdog_fault_q <= 1'b0;
      end else begin
         wdog_cnt_q   <= wdog_cnt_d;
         wdog_fault_q <= wdog_fault_d;
      end
   end

   assign wdog_fault = wdog_fault_q;
`else
   assign wdog_fault = 1'b0;
`endif

   assign exception = exc_q;
   assign eret      = eret_q;
   assign flush     = flush_q;
   assign busy      = busy_q;
   assign cause     = cause_q;
   assign exc_pc    = exc_pc_q;
   assign pending   = pend_vld_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed, table-driven bench for exc_ctrl plus hand-written watchdog/handler-hold sequence.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        req_syscall, req_break, req_ovf, req_teq;
   logic [31:0] req_pc;
   logic        eret_req;
   logic [31:0] status;
   logic        exception, eret, flush, busy, pending, wdog_fault;
   logic [1:0]  cause;
   logic [31:0] exc_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

`ifdef EXC_WDOG_EN
   exc_ctrl #(.WDOG_CYCLES(8), .WDOG_W(4)) dut (
`else
   exc_ctrl dut (
`endif
      .clk(clk), .rst(rst), .stall(stall),
      .req_syscall(req_syscall), .req_break(req_break), .req_ovf(req_ovf), .req_teq(req_teq),
      .req_pc(req_pc), .eret_req(eret_req), .status(status),
      .exception(exception), .eret(eret), .cause(cause), .exc_pc(exc_pc),
      .flush(flush), .busy(busy), .pending(pending), .wdog_fault(wdog_fault)
   );

   // req field is {teq, ovf, break, syscall}; exp is {exception, eret, cause, exc_pc, flush, busy, pending, wdog_fault}
   typedef struct {
      string       name;
      logic        rst_n;
      logic        stall;
      logic [3:0]  req;
      logic [31:0] pc;
      logic        eret_req;
      logic [31:0] status;
      logic [39:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [39:0] o(input logic ex, input logic er, input logic [1:0] c,
                                     input logic [31:0] pc, input logic fl, input logic bs,
                                     input logic pd);
      return {ex, er, c, pc, fl, bs, pd, 1'b0};
   endfunction

   function automatic vec_t v(input string n, input logic r, input logic s, input logic [3:0] q,
                              input logic [31:0] pc, input logic e, input logic [31:0] st,
                              input logic [39:0] x);
      vec_t t;
      t.name = n; t.rst_n = r; t.stall = s; t.req = q; t.pc = pc;
      t.eret_req = e; t.status = st; t.exp = x;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string n, input logic [39:0] got, input logic [39:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", n, got, want);
      end
   endtask

   function automatic logic [39:0] outs();
      return {exception, eret, cause, exc_pc, flush, busy, pending, wdog_fault};
   endfunction

   localparam logic [31:0] ST = 32'h1F;

   initial begin
      int seen;
      rst = 1'b0; stall = 1'b0; eret_req = 1'b0; status = ST; req_pc = 32'd0;
      {req_teq, req_ovf, req_break, req_syscall} = 4'b0;

      vecs.push_back(v("reset",        0, 0, 4'b0000, 32'h0,        0, ST,    o(0,0,0,32'h0,0,0,0)));
      vecs.push_back(v("idle_quiet",   1, 0, 4'b0000, 32'h0,        0, ST,    o(0,0,0,32'h0,0,0,0)));
      vecs.push_back(v("entry_sys",    1, 0, 4'b0001, 32'h00400010, 0, ST,    o(1,0,0,32'h00400010,1,1,0)));
      vecs.push_back(v("handler",      1, 0, 4'b0000, 32'h0,        0, ST,    o(0,0,0,32'h00400010,0,1,0)));
      vecs.push_back(v("eret_take",    1, 0, 4'b0000, 32'h0,        1, ST,    o(0,1,0,32'h00400010,0,1,0)));
      vecs.push_back(v("idle_after",   1, 0, 4'b0000, 32'h0,        0, ST,    o(0,0,0,32'h00400010,0,0,0)));
      vecs.push_back(v("spur_eret",    1, 0, 4'b0000, 32'h0,        1, ST,    o(0,0,0,32'h00400010,0,0,0)));
      vecs.push_back(v("mask_break",   1, 0, 4'b0010, 32'h00400030, 0, 32'h1B, o(0,0,0,32'h00400010,0,0,0)));
      vecs.push_back(v("mask_ie",      1, 0, 4'b1000, 32'h00400030, 0, 32'h1E, o(0,0,0,32'h00400010,0,0,0)));
      vecs.push_back(v("priority",     1, 0, 4'b1101, 32'h00400040, 0, ST,    o(1,0,3,32'h00400040,1,1,1)));
      vecs.push_back(v("enter_drop",   1, 0, 4'b0010, 32'h00400050, 0, ST,    o(0,0,3,32'h00400040,0,1,1)));
      vecs.push_back(v("eret_pend",    1, 0, 4'b0000, 32'h0,        1, ST,    o(0,1,3,32'h00400040,0,1,1)));
      vecs.push_back(v("idle_pend",    1, 0, 4'b0000, 32'h0,        0, ST,    o(0,0,3,32'h00400040,0,0,1)));
      vecs.push_back(v("replay_ovf",   1, 0, 4'b0000, 32'h0,        0, ST,    o(1,0,2,32'h00400040,1,1,0)));
      vecs.push_back(v("handler2",     1, 0, 4'b0000, 32'h0,        0, ST,    o(0,0,2,32'h00400040,0,1,0)));
      vecs.push_back(v("hdl_latch",    1, 0, 4'b0100, 32'h00400020, 0, ST,    o(0,0,2,32'h00400040,0,1,1)));
      vecs.push_back(v("eret2",        1, 0, 4'b0000, 32'h0,        1, ST,    o(0,1,2,32'h00400040,0,1,1)));
      vecs.push_back(v("idle2",        1, 0, 4'b0000, 32'h0,        0, ST,    o(0,0,2,32'h00400040,0,0,1)));
      vecs.push_back(v("replay2",      1, 0, 4'b0000, 32'h0,        0, ST,    o(1,0,2,32'h00400020,1,1,0)));
      vecs.push_back(v("stall_enter",  1, 1, 4'b0000, 32'h0,        0, ST,    o(0,0,2,32'h00400020,0,1,0)));
      vecs.push_back(v("stall_eret1",  1, 1, 4'b0000, 32'h0,        1, ST,    o(0,0,2,32'h00400020,0,1,0)));
      vecs.push_back(v("stall_eret2",  1, 1, 4'b0000, 32'h0,        1, ST,    o(0,0,2,32'h00400020,0,1,0)));
      vecs.push_back(v("stall_eret3",  1, 1, 4'b0000, 32'h0,        1, ST,    o(0,0,2,32'h00400020,0,1,0)));
      vecs.push_back(v("unstall_eret", 1, 0, 4'b0000, 32'h0,        1, ST,    o(0,1,2,32'h00400020,0,1,0)));
      vecs.push_back(v("idle3",        1, 0, 4'b0000, 32'h0,        0, ST,    o(0,0,2,32'h00400020,0,0,0)));
      vecs.push_back(v("stall_idle",   1, 1, 4'b0001, 32'h00400060, 0, ST,    o(0,0,2,32'h00400020,0,0,0)));
      vecs.push_back(v("unstall_req",  1, 0, 4'b0001, 32'h00400060, 0, ST,    o(1,0,0,32'h00400060,1,1,0)));
      vecs.push_back(v("handler3",     1, 0, 4'b0000, 32'h0,        0, ST,    o(0,0,0,32'h00400060,0,1,0)));
      vecs.push_back(v("req_and_eret", 1, 0, 4'b0010, 32'h00400070, 1, ST,    o(0,1,0,32'h00400060,0,1,1)));
      vecs.push_back(v("pend_masked",  1, 0, 4'b0000, 32'h0,        0, 32'h1B, o(0,0,0,32'h00400060,0,0,1)));
      vecs.push_back(v("live_beats",   1, 0, 4'b0001, 32'h00400080, 0, 32'h1B, o(1,0,0,32'h00400080,1,1,1)));
      vecs.push_back(v("handler4",     1, 0, 4'b0000, 32'h0,        0, ST,    o(0,0,0,32'h00400080,0,1,1)));
      vecs.push_back(v("reset_hdl",    0, 0, 4'b0000, 32'h0,        0, ST,    o(0,0,0,32'h0,0,0,0)));

      foreach (vecs[i]) begin
         rst      = vecs[i].rst_n;
         stall    = vecs[i].stall;
         {req_teq, req_ovf, req_break, req_syscall} = vecs[i].req;
         req_pc   = vecs[i].pc;
         eret_req = vecs[i].eret_req;
         status   = vecs[i].status;
         tick();
         check(vecs[i].name, outs(), vecs[i].exp);
      end

      // Handler hold: watchdog forces return after 8 handler cycles, otherwise wait forever.
      rst = 1'b1; stall = 1'b0; eret_req = 1'b0; status = ST;
      {req_teq, req_ovf, req_break, req_syscall} = 4'b1000; req_pc = 32'h00400090;
      tick();
      check("wd_entry", outs(), o(1,0,3,32'h00400090,1,1,0));
      {req_teq, req_ovf, req_break, req_syscall} = 4'b0000;
      seen = 0;
      for (int k = 1; k <= 40 && seen == 0; k++) begin
         tick();
         if (eret) seen = k;
      end
`ifdef EXC_WDOG_EN
      checks++;
      if (seen != 9) begin
         errors++;
         $display("FAIL wd_eret_cycle got %0d want 9", seen);
      end
      check("wd_return", outs(), {o(0,1,3,32'h00400090,0,1,0)} | 40'd1);
      tick();
      check("wd_sticky", outs(), {o(0,0,3,32'h00400090,0,0,0)} | 40'd1);
      tick();
      check("wd_sticky2", outs(), {o(0,0,3,32'h00400090,0,0,0)} | 40'd1);
`else
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL hold_no_eret got eret at cycle %0d want none", seen);
      end
      check("hold_state", outs(), o(0,0,3,32'h00400090,0,1,0));
      eret_req = 1'b1;
      tick();
      check("hold_release", outs(), o(0,1,3,32'h00400090,0,1,0));
      eret_req = 1'b0;
      tick();
      check("hold_idle", outs(), o(0,0,3,32'h00400090,0,0,0));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
